// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: handshake bundle around the instruction-fetch queue.
// The master side is the surrounding pipeline: pre-IF, the ROM response path, ID and
// the stall/flush/cancel controls. The slave side is the queue itself.
interface if_fetch_queue_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Pipeline control
    logic                  hold;
    logic                  flush;
    logic                  cancel;

    // pre-IF request side
    logic                  valid_pre;
    logic                  ready_go_pre;
    logic [BUS_WIDTH-1:0]  pc_pre;
    logic                  bp_taken_pre;
    logic [BUS_WIDTH-1:0]  pre_taken_target_pre;
    logic                  allow_in_if;

    // ROM response side
    logic                  mem_data_ok;
    logic [DATA_WIDTH-1:0] rom_rdata;

    // ID side
    logic                  allow_in_id;
    logic                  valid_if;
    logic                  ready_go_if;
    logic [BUS_WIDTH-1:0]  pc_if;
    logic [DATA_WIDTH-1:0] instruction_if;
    logic                  bp_taken_if;
    logic [BUS_WIDTH-1:0]  pre_taken_target_if;
    logic                  early_bp_wrong_if;
    logic [CNT_W-1:0]      occupancy;

    modport master (
        output hold, flush, cancel,
        output valid_pre, ready_go_pre, pc_pre, bp_taken_pre, pre_taken_target_pre,
        output mem_data_ok, rom_rdata,
        output allow_in_id,
        input  allow_in_if,
        input  valid_if, ready_go_if, pc_if, instruction_if, bp_taken_if,
        input  pre_taken_target_if, early_bp_wrong_if, occupancy
    );

    modport slave (
        input  hold, flush, cancel,
        input  valid_pre, ready_go_pre, pc_pre, bp_taken_pre, pre_taken_target_pre,
        input  mem_data_ok, rom_rdata,
        input  allow_in_id,
        output allow_in_if,
        output valid_if, ready_go_if, pc_if, instruction_if, bp_taken_if,
        output pre_taken_target_if, early_bp_wrong_if, occupancy
    );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: DEPTH-entry instruction-fetch queue between pre-IF and ID.
// Each accepted request takes an entry at wr_ptr. In-order ROM responses fill entries
// at fill_ptr, and ID pops from rd_ptr. A response that targets the head entry is
// bypassed straight to ID in the same cycle. On cancel every live entry is squashed.
// The responses still owed to squashed, unfilled entries are counted in drop_cnt and
// discarded when they arrive, so new fetches never stall behind them.
// Optional macro IF_EARLY_BP_CHECK_EN adds the early "taken but not a branch" check.
module if_fetch_queue #(
    parameter int          BUS_WIDTH  = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 4,
    parameter int          OP_WIDTH   = 7,
    parameter int unsigned SB_TYPE    = 7'b1100011
) (
    input  logic           clk,
    input  logic           rst_n,
    if_fetch_queue_if.slave bus
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Reject configurations the pointer arithmetic and opcode compare cannot handle.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || OP_WIDTH > DATA_WIDTH ||
        SB_TYPE >= (64'd1 << OP_WIDTH)) begin : g_param_check
        $error("if_fetch_queue: unsupported DEPTH / OP_WIDTH / SB_TYPE");
    end

    // Control state
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q,   fill_ptr_d;
    logic [CNT_W-1:0] occ_q,        occ_d;
    logic [CNT_W-1:0] unfilled_q,   unfilled_d;
    logic [CNT_W-1:0] drop_cnt_q,   drop_cnt_d;
    logic [DEPTH-1:0] data_vld_q,   data_vld_d;
    logic [CNT_W:0]   drop_sum;

    // Entry payload
    logic [BUS_WIDTH-1:0]  pc_mem_q   [DEPTH];
    logic [BUS_WIDTH-1:0]  tgt_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DEPTH-1:0]      bp_mem_q;

    // Per-cycle events
    logic                  valid;
    logic                  drop;
    logic                  fill;
    logic                  bypass;
    logic                  head_avail;
    logic                  rdy;
    logic                  commit;
    logic                  allow;
    logic                  acc;
    logic [DATA_WIDTH-1:0] head_instr;

    // Handshake decode: response fill/drop, head availability, commit and accept.
    always_comb begin
        valid      = (occ_q != '0);
        drop       = bus.mem_data_ok && (drop_cnt_q != '0);
        // A response with nothing pending and nothing to drop is ignored.
        fill       = bus.mem_data_ok && (drop_cnt_q == '0) && (unfilled_q != '0);
        // Unfilled entries always follow filled ones. When the fill target is the head,
        // every live entry is still waiting for its response.
        bypass     = fill && (fill_ptr_q == rd_ptr_q);
        head_avail = valid && (data_vld_q[rd_ptr_q] || bypass);
        rdy        = head_avail && !bus.hold;
        commit     = rdy && bus.allow_in_id;
        allow      = (occ_q < DEPTH_C) || commit;
        acc        = bus.valid_pre && bus.ready_go_pre && !bus.flush && allow;
        head_instr = bypass ? bus.rom_rdata : data_mem_q[rd_ptr_q];
    end

    // Next-state computation. Cancel overrides the normal pointer and counter updates
    // but keeps this cycle's accept as the redirect fetch.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d   = wr_ptr_q + PTR_W'(acc);
        rd_ptr_d   = rd_ptr_q + PTR_W'(commit);
        fill_ptr_d = fill_ptr_q + PTR_W'(fill);
        occ_d      = occ_q + CNT_W'(acc) - CNT_W'(commit);
        unfilled_d = unfilled_q + CNT_W'(acc) - CNT_W'(fill);
        drop_cnt_d = drop_cnt_q - CNT_W'(drop);
        drop_sum   = '0;

        data_vld_d = data_vld_q;
        if (fill)   data_vld_d[fill_ptr_q] = 1'b1;
        // Clears come after the set, so a bypassed-and-popped slot that is reallocated
        // in the same cycle starts out empty.
        if (commit) data_vld_d[rd_ptr_q]   = 1'b0;
        if (acc)    data_vld_d[wr_ptr_q]   = 1'b0;

        if (bus.cancel) begin
            rd_ptr_d   = wr_ptr_q;
            fill_ptr_d = wr_ptr_q;
            occ_d      = CNT_W'(acc);
            unfilled_d = CNT_W'(acc);
            // This cycle's response is charged first. Whatever stays unfilled is still
            // owed by the ROM and must be discarded when it arrives.
            drop_sum   = (CNT_W+1)'(drop_cnt_q - CNT_W'(drop)) +
                         (CNT_W+1)'(unfilled_q - CNT_W'(fill));
            drop_cnt_d = (drop_sum > (CNT_W+1)'(DEPTH)) ? DEPTH_C : drop_sum[CNT_W-1:0];
            data_vld_d = '0;
        end
    end

    // Control registers: pointers, counters and per-entry data-valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_ptr_q <= '0;
            occ_q      <= '0;
            unfilled_q <= '0;
            drop_cnt_q <= '0;
            data_vld_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            occ_q      <= occ_d;
            unfilled_q <= unfilled_d;
            drop_cnt_q <= drop_cnt_d;
            data_vld_q <= data_vld_d;
        end
    end

    // Payload storage: request fields on accept, instruction on fill.
    // NOTE: payload arrays are not reset; occupancy and data_vld gate every use of them.
    always_ff @(posedge clk) begin
        if (acc) begin
            pc_mem_q[wr_ptr_q]  <= bus.pc_pre;
            tgt_mem_q[wr_ptr_q] <= bus.pre_taken_target_pre;
            bp_mem_q[wr_ptr_q]  <= bus.bp_taken_pre;
        end
        if (fill) begin
            data_mem_q[fill_ptr_q] <= bus.rom_rdata;
        end
    end

    // Head presentation to ID. Fields read as zero while the queue is empty.
    assign bus.allow_in_if         = allow;
    assign bus.valid_if            = valid;
    assign bus.ready_go_if         = rdy;
    assign bus.occupancy           = occ_q;
    assign bus.pc_if               = valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.pre_taken_target_if = valid ? tgt_mem_q[rd_ptr_q] : '0;
    assign bus.bp_taken_if         = valid && bp_mem_q[rd_ptr_q];
    assign bus.instruction_if      = head_avail ? head_instr : '0;

`ifdef IF_EARLY_BP_CHECK_EN
    // Flag a taken prediction on an instruction that is not a conditional branch.
    assign bus.early_bp_wrong_if = head_avail && bp_mem_q[rd_ptr_q] &&
                                   (head_instr[OP_WIDTH-1:0] != OP_WIDTH'(SB_TYPE));
`else
    assign bus.early_bp_wrong_if = 1'b0;
`endif

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch queue between the pre-IF (PC generation / ROM request) stage and ID. It records every request accepted from pre-IF, captures in-order ROM responses, and presents instructions to ID with a valid/allow handshake. Up to DEPTH requests can be in flight or buffered, instead of a single slot. On cancel it squashes all older requests and drops their late responses without stalling new fetches.

## Interface
Parameters:
- BUS_WIDTH, 32: PC / target width.
- DATA_WIDTH, 32: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- OP_WIDTH, 7: opcode field width.
- SB_TYPE, 7'b1100011: conditional-branch opcode.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- hold  in  1  stall; forces ready_go_if=0.
- flush  in  1  blocks acceptance from pre-IF this cycle.
- cancel  in  1  squash all queued/in-flight entries.
- valid_pre, ready_go_pre  in  1 each  pre-IF offers a request.
- pc_pre  in  BUS_WIDTH  request PC.
- bp_taken_pre  in  1  predicted taken.
- pre_taken_target_pre  in  BUS_WIDTH  predicted target.
- allow_in_if  out  1  queue can accept a request.
- mem_data_ok  in  1  ROM response valid; in request order.
- rom_rdata  in  DATA_WIDTH  ROM response data.
- allow_in_id  in  1  ID accepts.
- valid_if  out  1  head entry live.
- ready_go_if  out  1  head instruction available and not held.
- pc_if  out  BUS_WIDTH  head PC.
- instruction_if  out  DATA_WIDTH  head instruction.
- bp_taken_if  out  1  head prediction, gated by valid_if.
- pre_taken_target_if  out  BUS_WIDTH  head target.
- early_bp_wrong_if  out  1  taken-predicted non-branch at head.
- occupancy  out  clog2(DEPTH)+1  live entries.

## Operation
- Accept: acc = valid_pre & ready_go_pre & !flush & allow_in_if. Allocates at wr_ptr: pc, bp_taken, target; data_vld=0.
- allow_in_if = (occupancy < DEPTH) | commit; combinational, so a full queue accepts when its head commits the same cycle.
- Response: if mem_data_ok and drop_cnt≠0, the response is discarded and drop_cnt decrements. Otherwise it writes rom_rdata to the entry at fill_ptr, sets data_vld, and advances fill_ptr.
- Bypass: when the head is the fill target and the response is not dropped, instruction_if = rom_rdata in that cycle.
- valid_if = occupancy≠0.
- ready_go_if = valid_if & (head data_vld | live response for head) & !hold.
- commit = ready_go_if & allow_in_id; pops head (rd_ptr+1).
- Cancel:
  - All live entries are invalidated: rd_ptr=fill_ptr=wr_ptr, occupancy=0 apart from same-cycle acc.
  - drop_cnt += entries allocated but not yet filled, counted after this cycle's response.
  - A same-cycle acc is kept; it is the redirect fetch.
  - A same-cycle commit still completes.
- Pointers wrap modulo DEPTH.
- drop_cnt is clog2(DEPTH)+1 bits and never exceeds DEPTH.
- mem_data_ok with no pending entry and drop_cnt=0 is a protocol error and is ignored (assertion in bench).

## Timing
- Reset (async assert, sync-safe deassert):
  - Pointers, occupancy, drop_cnt = 0; all data_vld = 0.
  - valid_if = 0, ready_go_if = 0, bp_taken_if = 0, early_bp_wrong_if = 0.
  - pc_if = 0, instruction_if = 0, pre_taken_target_if = 0, occupancy = 0.
  - allow_in_if = 1.
- Latency:
  - acc at cycle N: entry visible (valid_if=1) at N+1.
  - Response at cycle M ≥ N+1 with entry at head: ready_go_if=1 in M (bypass).
  - Otherwise the instruction is stored and presented once the entry reaches head.
- Simultaneous acc, response and commit in one cycle are all honoured; occupancy += acc − commit.
- cancel with mem_data_ok in the same cycle: the response is counted against pre-cancel entries. It fills or drops first, then the remaining unfilled count is added to drop_cnt.
- hold freezes commit only; acceptance and response capture continue.

## Configuration
- IF_EARLY_BP_CHECK_EN defined: early_bp_wrong_if = valid_if & bp_taken(head) & (instruction_if[OP_WIDTH-1:0] ≠ SB_TYPE) & head instruction available.
- IF_EARLY_BP_CHECK_EN undefined: early_bp_wrong_if tied 0; no opcode decode logic.

## Test plan
- Reset mid-stream with 3 entries live: all outputs return to reset values immediately (async), allow_in_if=1, occupancy=0.
- Back-to-back fetch: accept PCs 0x0,0x4,0x8,0xC, responses one cycle later, allow_in_id=1 → ID sees the same four PCs in order with their data, one per cycle, via bypass.
- Full queue: DEPTH=4, allow_in_id=0, 4 accepted → allow_in_if=0. Raise allow_in_id → allow_in_if=1 in the same cycle and a 5th PC is accepted while the head commits.
- Cancel with 3 unfilled entries plus a same-cycle acc of PC 0x100 → drop_cnt=3. The next 3 responses are dropped; the 4th response is presented with pc_if=0x100.
- hold=1 with head filled → ready_go_if=0 and no pop. Responses to later entries are still stored. hold=0 → head commits next.
- IF_EARLY_BP_CHECK_EN: head bp_taken=1 with rom_rdata opcode 0x13 → early_bp_wrong_if=1. Opcode 0x63 → 0. Macro off → always 0.
